irq_trigger_gen: RTL and testbench

//  Multi-channel, register-programmable interrupt stimulus generator for MIPS CPU benches.
//  - Watches the CPU's current PC (addr); each armed channel that matches its trigger PC drives one HWInt line.
//  - The line is held for a programmed pulse length, re-arming up to a programmed fire limit.
//  - Placed beside mips in system/bench tops; irq[] feeds the CP0 HWInt inputs.

---
 rtl/irq_trigger_gen_pkg.sv | 25 ++
 rtl/irq_trigger_gen_channel.sv | 128 ++++++++++++
 rtl/irq_trigger_gen.sv | 52 +++++
 tb/tb_irq_trigger_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_trigger_gen_pkg.sv
// Shared definitions for the PC-triggered interrupt generator: channel states, config selects, CTRL bits.
// Latency: none (definitions only).
// Backpressure: none. Optional feature macro IRQ_ACK_EN is handled in the channel and top files.
package irq_trigger_gen_pkg;

  // Per-channel sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_DONE    = 3'd4
  } ch_state_e;

  // cfg_sel field decode
  localparam logic [1:0] CFG_SEL_TRIG_PC    = 2'd0;
  localparam logic [1:0] CFG_SEL_PULSE_LEN  = 2'd1;
  localparam logic [1:0] CFG_SEL_FIRE_LIMIT = 2'd2;
  localparam logic [1:0] CFG_SEL_CTRL       = 2'd3;

  // Bit positions inside a CTRL write
  localparam int CTRL_ARM = 0;
  localparam int CTRL_CLR = 1;

endpackage

// File: rtl/irq_trigger_gen_channel.sv
// One interrupt channel: config registers plus IDLE/ARMED/ACTIVE/HOLDOFF/DONE sequencer.
// Latency: irq rises the cycle after the PC match edge; falls the cycle after the pulse ends or is aborted.
// Backpressure: none; with IRQ_ACK_EN defined the pulse is held until irq_ack_i instead of timed.
module irq_trigger_gen_channel
  import irq_trigger_gen_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              cfg_we_i,
  input  logic [1:0]        cfg_sel_i,
  input  logic [ADDR_W-1:0] cfg_wdata_i,
`ifdef IRQ_ACK_EN
  input  logic              irq_ack_i,
`endif
  output logic              irq_o,
  output logic              active_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ch_state_e         state_q;
  logic [ADDR_W-1:0] trig_pc_q;
  logic [CNT_W-1:0]  pulse_len_q;
  logic [CNT_W-1:0]  fire_limit_q;
  logic [CNT_W-1:0]  fires_q;
  logic              irq_q;
`ifndef IRQ_ACK_EN
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
`endif

  logic [CNT_W-1:0]  cfg_field;
  logic [CNT_W-1:0]  fires_d;
  logic              pc_hit;
  logic              rearm_ok;
  logic              pulse_end;

  assign cfg_field = cfg_wdata_i[CNT_W-1:0];
  assign pc_hit    = (addr_i == trig_pc_q);
  // Fire count saturates instead of wrapping so a limit compare can never be fooled
  assign fires_d   = (&fires_q) ? fires_q : fires_q + CNT_ONE;
  // A limit of zero means the channel re-arms forever
  assign rearm_ok  = (fire_limit_q == '0) || (fires_q < fire_limit_q);

`ifdef IRQ_ACK_EN
  assign pulse_end = irq_ack_i;
`else
  // A programmed length of zero still gives a one-cycle pulse
  assign cnt_d     = (pulse_len_q == '0) ? CNT_ONE : pulse_len_q;
  assign pulse_end = (cnt_q == CNT_ONE);
`endif

  // Sequencer and config registers; config writes are applied last so they override the sequencer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      trig_pc_q    <= '0;
      pulse_len_q  <= CNT_ONE;
      fire_limit_q <= CNT_ONE;
      fires_q      <= '0;
      irq_q        <= 1'b0;
`ifndef IRQ_ACK_EN
      cnt_q        <= '0;
`endif
    end else begin
      case (state_q)
        ST_ARMED: begin
          // A config write to this channel in the same cycle suppresses the match
          if (!cfg_we_i && pc_hit) begin
            state_q <= ST_ACTIVE;
            fires_q <= fires_d;
            irq_q   <= 1'b1;
`ifndef IRQ_ACK_EN
            cnt_q   <= cnt_d;
`endif
          end
        end
        ST_ACTIVE: begin
          if (pulse_end) begin
            irq_q   <= 1'b0;
            state_q <= rearm_ok ? ST_HOLDOFF : ST_DONE;
          end
`ifndef IRQ_ACK_EN
          else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
`endif
        end
        // Wait for the PC to leave the target so a parked PC cannot retrigger
        ST_HOLDOFF: begin
          if (!pc_hit) begin
            state_q <= ST_ARMED;
          end
        end
        default: begin
        end
      endcase

      if (cfg_we_i) begin
        case (cfg_sel_i)
          CFG_SEL_TRIG_PC:    trig_pc_q    <= cfg_wdata_i;
          CFG_SEL_PULSE_LEN:  pulse_len_q  <= cfg_field;
          CFG_SEL_FIRE_LIMIT: fire_limit_q <= cfg_field;
          default: begin
            if (cfg_wdata_i[CTRL_CLR]) begin
              fires_q <= '0;
            end
            if (!cfg_wdata_i[CTRL_ARM]) begin
              // Disarm aborts from any state, including mid-pulse
              state_q <= ST_IDLE;
              irq_q   <= 1'b0;
            end else if (state_q == ST_IDLE || state_q == ST_DONE) begin
              state_q <= ST_ARMED;
            end
          end
        endcase
      end
    end
  end

  assign irq_o    = irq_q;
  assign active_o = (state_q == ST_ACTIVE);

endmodule

// File: rtl/irq_trigger_gen.sv
// PC-triggered multi-channel interrupt stimulus generator; one channel instance per irq line.
// Latency: irq registered, one cycle after the matching PC edge; busy follows channel ACTIVE state.
// Backpressure: none; IRQ_ACK_EN adds irq_ack so pulses are held until acknowledged.
module irq_trigger_gen
  import irq_trigger_gen_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_wdata,
`ifdef IRQ_ACK_EN
  input  logic [NUM_CH-1:0] irq_ack,
`endif
  output logic [NUM_CH-1:0] irq,
  output logic              busy
);

  logic [NUM_CH-1:0] ch_we;
  logic [NUM_CH-1:0] ch_active;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Channel numbers at or beyond NUM_CH decode to no channel, so such writes vanish
    assign ch_we[g] = cfg_we && (cfg_ch == 3'(g));

    irq_trigger_gen_channel #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_channel (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .addr_i      (addr),
      .cfg_we_i    (ch_we[g]),
      .cfg_sel_i   (cfg_sel),
      .cfg_wdata_i (cfg_wdata),
`ifdef IRQ_ACK_EN
      .irq_ack_i   (irq_ack[g]),
`endif
      .irq_o       (irq[g]),
      .active_o    (ch_active[g])
    );
  end

  assign busy = |ch_active;

endmodule

// File: tb/tb_irq_trigger_gen.sv
module tb_irq_trigger_gen;

  localparam logic [1:0] SEL_TRIG  = 2'd0;
  localparam logic [1:0] SEL_LEN   = 2'd1;
  localparam logic [1:0] SEL_LIMIT = 2'd2;
  localparam logic [1:0] SEL_CTRL  = 2'd3;
  localparam logic [31:0] PC_IDLE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic [5:0]  irq;
  logic        busy;
`ifdef IRQ_ACK_EN
  logic [5:0]  irq_ack;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected {busy, irq} per clock, with a tag
  logic [6:0] exp_q[$];
  string      tag_q[$];

  irq_trigger_gen dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr      (addr),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_wdata (cfg_wdata),
`ifdef IRQ_ACK_EN
    .irq_ack   (irq_ack),
`endif
    .irq       (irq),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] e);
    checks++;
    assert ({busy, irq} === e)
    else begin
      errors++;
      $error("FAIL %s busy_irq observed=%b expected=%b", tag, {busy, irq}, e);
    end
  endtask

  task automatic expect_n(input int n, input logic [5:0] irq_e, input logic busy_e, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({busy_e, irq_e});
      tag_q.push_back(tag);
    end
  endtask

  // Advance one clock, sample 1 time unit later, compare against the oldest expectation
  task automatic tick();
    logic [6:0] e;
    string t;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, e);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] ch, input logic [1:0] sel, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_ch    = ch;
    cfg_sel   = sel;
    cfg_wdata = d;
  endtask

  task automatic wr_off();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic setw(input logic [2:0] ch, input logic [1:0] sel, input logic [31:0] d);
    wr(ch, sel, d);
    tick();
    wr_off();
  endtask

  initial begin
    reset_n   = 1'b0;
    addr      = PC_IDLE;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_sel   = '0;
    cfg_wdata = '0;
`ifdef IRQ_ACK_EN
    irq_ack   = '0;
`endif
    #3;
    check("reset_state", 7'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

`ifdef IRQ_ACK_EN
    // Acknowledge mode: held pulse, ack in trigger cycle ignored
    setw(3'd5, SEL_TRIG, 32'h30c0);
    setw(3'd5, SEL_CTRL, 32'h1);
    addr = 32'h30c0; irq_ack = 6'b100000;
    expect_n(1, 6'b100000, 1'b1, "ack_rise"); ticks(1);
    addr = PC_IDLE; irq_ack = '0;
    expect_n(9, 6'b100000, 1'b1, "ack_hold"); ticks(9);
    irq_ack = 6'b100000;
    expect_n(1, 6'b000000, 1'b0, "ack_drop"); ticks(1);
    expect_n(2, 6'b000000, 1'b0, "ack_after"); ticks(2);
    irq_ack = '0;
    // Re-arm and kill with reset mid-pulse
    setw(3'd5, SEL_CTRL, 32'h1);
    addr = 32'h30c0;
    expect_n(2, 6'b100000, 1'b1, "ack_pulse2"); ticks(1);
    addr = PC_IDLE; ticks(1);
    #1 reset_n = 1'b0;
    #1 check("ack_async_reset", 7'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    expect_n(2, 6'b000000, 1'b0, "ack_post_reset"); ticks(2);
`else
    // 1: single shot on ch0, 6-cycle pulse, then DONE
    setw(3'd0, SEL_TRIG, 32'h301c);
    setw(3'd0, SEL_LEN, 32'd6);
    setw(3'd0, SEL_CTRL, 32'h1);
    addr = 32'h301c;
    expect_n(1, 6'b000001, 1'b1, "t1_rise"); ticks(1);
    addr = PC_IDLE;
    expect_n(5, 6'b000001, 1'b1, "t1_hold");
    expect_n(3, 6'b000000, 1'b0, "t1_done"); ticks(8);
    addr = 32'h301c;
    expect_n(2, 6'b000000, 1'b0, "t1_no_refire"); ticks(2);
    addr = PC_IDLE;

    // 2: ch1 fires three times, holdoff while parked, fourth visit silent
    setw(3'd1, SEL_TRIG, 32'h3040);
    setw(3'd1, SEL_LEN, 32'd2);
    setw(3'd1, SEL_LIMIT, 32'd3);
    setw(3'd1, SEL_CTRL, 32'h1);
    for (int v = 0; v < 3; v++) begin
      addr = 32'h3040;
      expect_n(2, 6'b000010, 1'b1, "t2_pulse"); ticks(2);
      if (v == 0) begin
        expect_n(3, 6'b000000, 1'b0, "t2_parked"); ticks(3);
      end
      addr = PC_IDLE;
      expect_n(2, 6'b000000, 1'b0, "t2_gap"); ticks(2);
    end
    addr = 32'h3040;
    expect_n(2, 6'b000000, 1'b0, "t2_fourth"); ticks(2);
    addr = PC_IDLE;

    // 3: ch2/ch3 share a trigger, lengths 1 and 4
    setw(3'd2, SEL_TRIG, 32'h3000);
    setw(3'd2, SEL_LEN, 32'd1);
    setw(3'd3, SEL_TRIG, 32'h3000);
    setw(3'd3, SEL_LEN, 32'd4);
    setw(3'd2, SEL_CTRL, 32'h1);
    setw(3'd3, SEL_CTRL, 32'h1);
    addr = 32'h3000;
    expect_n(1, 6'b001100, 1'b1, "t3_both"); ticks(1);
    addr = PC_IDLE;
    expect_n(3, 6'b001000, 1'b1, "t3_ch3");
    expect_n(1, 6'b000000, 1'b0, "t3_end"); ticks(4);

    // 4: abort ch0 in its third active cycle, then re-arm
    setw(3'd0, SEL_CTRL, 32'h3);
    addr = 32'h301c;
    expect_n(1, 6'b000001, 1'b1, "t4_rise"); ticks(1);
    addr = PC_IDLE;
    expect_n(2, 6'b000001, 1'b1, "t4_hold"); ticks(2);
    wr(3'd0, SEL_CTRL, 32'h0);
    expect_n(1, 6'b000000, 1'b0, "t4_abort"); ticks(1);
    wr_off();
    addr = 32'h301c;
    expect_n(2, 6'b000000, 1'b0, "t4_idle"); ticks(2);
    wr(3'd0, SEL_CTRL, 32'h3);
    expect_n(1, 6'b000000, 1'b0, "t4_rearm"); ticks(1);
    wr_off();
    expect_n(6, 6'b000001, 1'b1, "t4_refire"); ticks(1);
    addr = PC_IDLE; ticks(5);
    expect_n(1, 6'b000000, 1'b0, "t4_end"); ticks(1);

    // 5: write wins over match; out-of-range channel writes ignored
    setw(3'd4, SEL_TRIG, 32'h3080);
    setw(3'd4, SEL_LEN, 32'd2);
    setw(3'd4, SEL_CTRL, 32'h1);
    addr = 32'h3080;
    wr(3'd4, SEL_LEN, 32'd3);
    expect_n(1, 6'b000000, 1'b0, "t5_write_wins"); ticks(1);
    wr_off();
    addr = PC_IDLE;
    expect_n(1, 6'b000000, 1'b0, "t5_quiet"); ticks(1);
    addr = 32'h3080;
    expect_n(3, 6'b010000, 1'b1, "t5_new_len"); ticks(1);
    addr = PC_IDLE; ticks(2);
    expect_n(1, 6'b000000, 1'b0, "t5_end"); ticks(1);
    setw(3'd5, SEL_TRIG, 32'h30c0);
    setw(3'd5, SEL_CTRL, 32'h1);
    wr(3'd7, SEL_CTRL, 32'h0);
    expect_n(1, 6'b000000, 1'b0, "t5_ch7_ctrl"); ticks(1);
    wr(3'd6, SEL_TRIG, 32'h1234);
    expect_n(1, 6'b000000, 1'b0, "t5_ch6_trig"); ticks(1);
    wr_off();
    addr = 32'h30c0;
    expect_n(1, 6'b100000, 1'b1, "t5_ch5_intact"); ticks(1);
    addr = PC_IDLE;
    expect_n(1, 6'b000000, 1'b0, "t5_ch5_end"); ticks(1);

    // 6: reset mid-pulse drops irq at once and restores config defaults
    setw(3'd0, SEL_CTRL, 32'h1);
    addr = 32'h301c;
    expect_n(2, 6'b000001, 1'b1, "t6_pulse"); ticks(1);
    addr = PC_IDLE; ticks(1);
    #1 reset_n = 1'b0;
    #1 check("t6_async_drop", 7'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    setw(3'd0, SEL_CTRL, 32'h1);
    addr = 32'h0;
    expect_n(1, 6'b000001, 1'b1, "t6_default_trig"); ticks(1);
    addr = PC_IDLE;
    expect_n(2, 6'b000000, 1'b0, "t6_default_len"); ticks(2);
`endif

    checks++;
    assert (exp_q.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
